// File: rtl/i2c_line_conditioner.sv
// I2C input conditioning: 2-flop synchronizers, per-line glitch filters,
// registered SCL edge / START / repeated START / STOP pulses and bus busy/free status.
module i2c_line_conditioner #(
    parameter int unsigned FILTER_CYCLES   = 4,
    parameter int unsigned BUS_FREE_CYCLES = 127
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic rep_start_o,
    output logic stop_o,
    output logic bus_busy_o,
    output logic bus_free_o
);

    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned BW = $clog2(BUS_FREE_CYCLES + 1);

    logic [1:0]    scl_sync, sda_sync;
    logic [FW-1:0] scl_cnt, sda_cnt;
    logic          scl_filt, sda_filt;
    logic          scl_dly, sda_dly;
    logic          busy;
    logic          busy_next;
    logic [BW-1:0] free_cnt;
    logic          start_cond, stop_cond;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};

            // A differing level is accepted on the edge its run reaches FILTER_CYCLES.
            if (scl_sync[1] == scl_filt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FW'(FILTER_CYCLES - 1)) begin
                scl_filt <= scl_sync[1];
                scl_cnt  <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end

            if (sda_sync[1] == sda_filt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FW'(FILTER_CYCLES - 1)) begin
                sda_filt <= sda_sync[1];
                sda_cnt  <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    // SCL must be high both now and one cycle ago, so simultaneous edges never qualify.
    assign start_cond = scl_filt && scl_dly && !sda_filt &&  sda_dly;
    assign stop_cond  = scl_filt && scl_dly &&  sda_filt && !sda_dly;

    always_comb begin
        busy_next = busy;
        if (start_cond && !busy) begin
            busy_next = 1'b1;
        end else if (stop_cond) begin
            busy_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_dly     <= 1'b1;
            sda_dly     <= 1'b1;
            scl_rise_o  <= 1'b0;
            scl_fall_o  <= 1'b0;
            start_o     <= 1'b0;
            rep_start_o <= 1'b0;
            stop_o      <= 1'b0;
        end else begin
            scl_dly     <= scl_filt;
            sda_dly     <= sda_filt;
            scl_rise_o  <= scl_filt && !scl_dly;
            scl_fall_o  <= !scl_filt && scl_dly;
            start_o     <= start_cond && !busy;
            rep_start_o <= start_cond && busy;
            stop_o      <= stop_cond;
        end
    end

    // Counting against the post-edge busy state lets a STOP start the idle count on its own edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy     <= 1'b0;
            free_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (busy_next || !scl_filt || !sda_filt) begin
                free_cnt <= '0;
            end else if (free_cnt != BW'(BUS_FREE_CYCLES)) begin
                free_cnt <= free_cnt + 1'b1;
            end
        end
    end

    assign scl_o      = scl_filt;
    assign sda_o      = sda_filt;
    assign bus_busy_o = busy;
    assign bus_free_o = (free_cnt == BW'(BUS_FREE_CYCLES)) && !busy;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Bench for i2c_line_conditioner: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed edge counts.
module tb_i2c_line_conditioner;

    localparam int unsigned FC = 4;
    localparam int unsigned NF = 127;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic scl_raw = 1'b1;
    logic sda_raw = 1'b1;
    logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, rep_start_o, stop_o;
    logic bus_busy_o, bus_free_o;

    int checks = 0;
    int failures = 0;

    i2c_line_conditioner #(
        .FILTER_CYCLES(FC),
        .BUS_FREE_CYCLES(NF)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .scl_i(scl_raw),
        .sda_i(sda_raw),
        .scl_o(scl_o),
        .sda_o(sda_o),
        .scl_rise_o(scl_rise_o),
        .scl_fall_o(scl_fall_o),
        .start_o(start_o),
        .rep_start_o(rep_start_o),
        .stop_o(stop_o),
        .bus_busy_o(bus_busy_o),
        .bus_free_o(bus_free_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: raw samples per edge; a line flips when the last FC
    // synchronized samples all disagree with its current filtered level.
    bit hs[$];
    bit hd[$];
    bit m_scl, m_sda, m_scl_prev, m_sda_prev;
    bit e_rise, e_fall, e_start, e_rep, e_stop;
    bit m_busy;
    int m_idle;

    task automatic model_reset();
        hs.delete();
        hd.delete();
        for (int i = 0; i <= int'(FC); i++) begin
            hs.push_back(1'b1);
            hd.push_back(1'b1);
        end
        m_scl = 1'b1; m_sda = 1'b1; m_scl_prev = 1'b1; m_sda_prev = 1'b1;
        e_rise = 1'b0; e_fall = 1'b0; e_start = 1'b0; e_rep = 1'b0; e_stop = 1'b0;
        m_busy = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_step();
        bit cs, cd, ps, pd, flip_s, flip_d, sda_fell, sda_rose;
        cs = m_scl; cd = m_sda; ps = m_scl_prev; pd = m_sda_prev;
        flip_s = 1'b1;
        flip_d = 1'b1;
        for (int i = 0; i < int'(FC); i++) begin
            if (hs[i] == cs) flip_s = 1'b0;
            if (hd[i] == cd) flip_d = 1'b0;
        end
        e_rise = cs && !ps;
        e_fall = !cs && ps;
        sda_fell = cs && ps && !cd && pd;
        sda_rose = cs && ps && cd && !pd;
        e_start = sda_fell && !m_busy;
        e_rep = sda_fell && m_busy;
        e_stop = sda_rose;
        if (e_start) m_busy = 1'b1;
        else if (e_stop) m_busy = 1'b0;
        if (m_busy || !cs || !cd) m_idle = 0;
        else if (m_idle < int'(NF)) m_idle++;
        m_scl_prev = cs;
        m_sda_prev = cd;
        if (flip_s) m_scl = !cs;
        if (flip_d) m_sda = !cd;
        hs.push_back(scl_raw);
        hd.push_back(sda_raw);
        void'(hs.pop_front());
        void'(hd.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("scl_o", scl_o, m_scl);
            chk("sda_o", sda_o, m_sda);
            chk("scl_rise", scl_rise_o, e_rise);
            chk("scl_fall", scl_fall_o, e_fall);
            chk("start", start_o, e_start);
            chk("rep_start", rep_start_o, e_rep);
            chk("stop", stop_o, e_stop);
            chk("bus_busy", bus_busy_o, m_busy);
            chk("bus_free", bus_free_o, (m_idle == int'(NF)) && !m_busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    int n_rise, n_fall, n_start, n_rep, n_stop;

    task automatic clr_counts();
        n_rise = 0; n_fall = 0; n_start = 0; n_rep = 0; n_stop = 0;
    endtask

    task automatic sample_counts();
        n_rise += int'(scl_rise_o);
        n_fall += int'(scl_fall_o);
        n_start += int'(start_o);
        n_rep += int'(rep_start_o);
        n_stop += int'(stop_o);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_counts();
        end
    endtask

    task automatic scl_pulse();
        scl_raw = 1'b0;
        cyc(8);
        scl_raw = 1'b1;
        cyc(8);
    endtask

    int first_a, first_b;
    bit saw_low;

    initial begin
        clr_counts();
        #1 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;

        // Idle after reset: bus_free after edge 127, i.e. in cycle 128.
        clr_counts();
        first_a = -1;
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk);
            #1;
            sample_counts();
            if (bus_free_o) begin
                first_a = e;
                break;
            end
        end
        chk("reset_free_edge", first_a, 127);
        chk("reset_no_events", n_rise + n_fall + n_start + n_rep + n_stop, 0);

        // 3-cycle low glitch is swallowed.
        clr_counts();
        saw_low = 1'b0;
        scl_raw = 1'b0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk);
            #1;
            sample_counts();
            if (e == 2) scl_raw = 1'b1;
            if (!scl_o) saw_low = 1'b1;
        end
        chk("glitch3_scl_low", saw_low, 0);
        chk("glitch3_fall", n_fall, 0);

        // 4-cycle low passes: scl_o falls on edge 5, scl_fall_o on edge 6.
        first_a = -1;
        first_b = -1;
        scl_raw = 1'b0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) scl_raw = 1'b1;
            if (!scl_o && first_a < 0) first_a = e;
            if (scl_fall_o && first_b < 0) first_b = e;
        end
        chk("low4_scl_edge", first_a, 5);
        chk("low4_fall_edge", first_b, 6);
        cyc(140);
        chk("free_before_start", bus_free_o, 1);

        // START from idle, then eight SCL pulses.
        clr_counts();
        sda_raw = 1'b0;
        cyc(12);
        chk("start_count", n_start, 1);
        chk("start_rep_count", n_rep, 0);
        chk("start_busy", bus_busy_o, 1);
        chk("start_free", bus_free_o, 0);
        clr_counts();
        repeat (8) scl_pulse();
        chk("byte_rises", n_rise, 8);
        chk("byte_falls", n_fall, 8);

        // Repeated START while busy.
        scl_raw = 1'b0;
        cyc(8);
        sda_raw = 1'b1;
        cyc(8);
        scl_raw = 1'b1;
        cyc(8);
        clr_counts();
        sda_raw = 1'b0;
        cyc(12);
        chk("rep_count", n_rep, 1);
        chk("rep_start_count", n_start, 0);
        chk("rep_busy", bus_busy_o, 1);

        // STOP; bus_free follows the filtered SDA rise by exactly NF edges.
        scl_raw = 1'b0;
        cyc(8);
        scl_raw = 1'b1;
        cyc(8);
        clr_counts();
        sda_raw = 1'b1;
        first_a = -1;
        first_b = -1;
        for (int e = 0; e < 400; e++) begin
            @(posedge clk);
            #1;
            sample_counts();
            if (sda_o && first_a < 0) first_a = e;
            if (bus_free_o) begin
                first_b = e;
                break;
            end
        end
        chk("stop_count", n_stop, 1);
        chk("stop_busy", bus_busy_o, 0);
        chk("stop_free_delay", first_b - first_a, 127);

        // Both lines fall together: SCL edge only.
        clr_counts();
        scl_raw = 1'b0;
        sda_raw = 1'b0;
        cyc(12);
        chk("both_fall", n_fall, 1);
        chk("both_start", n_start, 0);
        chk("both_busy", bus_busy_o, 0);

        // STOP while idle still pulses, busy stays low.
        scl_raw = 1'b1;
        cyc(8);
        clr_counts();
        sda_raw = 1'b1;
        cyc(10);
        chk("idle_stop_count", n_stop, 1);
        chk("idle_stop_busy", bus_busy_o, 0);

        // Reset in the middle of a byte, lines held low through reset.
        sda_raw = 1'b0;
        cyc(10);
        scl_pulse();
        scl_pulse();
        scl_raw = 1'b0;
        cyc(8);
        chk("midbyte_busy", bus_busy_o, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_scl", scl_o, 1);
        chk("rst_sda", sda_o, 1);
        chk("rst_pulses", {scl_rise_o, scl_fall_o, start_o, rep_start_o, stop_o}, 0);
        chk("rst_busy", bus_busy_o, 0);
        chk("rst_free", bus_free_o, 0);
        cyc(3);
        rst_n = 1'b1;
        clr_counts();
        first_a = -1;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            sample_counts();
            if (scl_fall_o && first_a < 0) first_a = e;
        end
        chk("post_rst_fall_edge", first_a, 7);
        chk("post_rst_start", n_start + n_rep, 0);

        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
